// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial subtract controller.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             barr;

    modport master (output start, a, b, input busy, done, diff, barr);
    modport slave  (input start, a, b, output busy, done, diff, barr);
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b controller driving one full-subtractor cell over WIDTH cycles.
// Optional SERIAL_SUB_SAT_EN: clamp diff to zero when the final borrow is set.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_sub_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             barr_q, barr_d;
    logic             load, step;
    logic             d_bit, bout;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] final_diff;

    assign d_bit = sa_q[0] ^ sb_q[0] ^ bor_q;
    assign bout  = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & bor_q) | (sb_q[0] & bor_q);

    // res_shift is the result register after this step's bit enters at the MSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = d_bit;
        end else begin : g_res
            logic [WIDTH-2:0] res_q;
            assign res_shift = {d_bit, res_q};
            always_ff @(posedge clk) begin
                if (rst || load) res_q <= '0;
                else if (step)   res_q <= res_shift[WIDTH-1:1];
            end
        end
    endgenerate

`ifdef SERIAL_SUB_SAT_EN
    assign final_diff = bout ? '0 : res_shift;
`else
    assign final_diff = res_shift;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            barr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            barr_q  <= barr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        barr_d  = barr_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            RUN: begin
                step  = 1'b1;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                bor_d = bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = final_diff;
                    barr_d  = bout;
                    state_d = DONE;
                end
            end
            default: begin
                // IDLE and DONE accept a new request identically.
                state_d = IDLE;
                if (bus.start) begin
                    load    = 1'b1;
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.barr = barr_q;
endmodule
